// File: rtl/mac_accum_ctrl.sv
// Accumulator register and job sequencer for the MAC datapath: sums a programmed
// number of unsigned products and returns the total with a sticky carry-out flag.
module mac_accum_ctrl #(
  parameter int PROD_W = 33,
  parameter int ACC_W  = 34,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              acc_ovf,
  output logic              busy,
  output logic [CNT_W-1:0]  terms_left
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next, sum;
  logic               ovf, ovf_next;
  logic [CNT_W-1:0]   cnt, cnt_next;

  // Product top bit is always 0, so a carry shows up as the accumulator MSB
  // falling from 1 to 0 across the addition.
  function automatic logic carry_out(input logic [ACC_W-1:0] a,
                                     input logic [ACC_W-1:0] s);
    return a[ACC_W-1] & ~s[ACC_W-1];
  endfunction

  assign sum = acc + {{(ACC_W-PROD_W){1'b0}}, prod_data};

  always_comb begin
    state_next = state;
    acc_next   = acc;
    ovf_next   = ovf;
    cnt_next   = cnt;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_next = '0;
          ovf_next = 1'b0;
          if (num_terms != '0) begin
            cnt_next   = num_terms;
            state_next = ACC;
          end else begin
            state_next = DONE;
          end
        end
      end
      ACC: begin
        prod_ready = 1'b1;
        if (prod_valid) begin
          acc_next = sum;
          if (carry_out(acc, sum)) ovf_next = 1'b1;
          cnt_next = cnt - 1'b1;
          if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) state_next = DONE;
        end
      end
      DONE: begin
        acc_valid = 1'b1;
        if (acc_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      ovf   <= ovf_next;
      cnt   <= cnt_next;
    end
  end

  assign acc_data   = acc;
  assign acc_ovf    = ovf;
  assign busy       = (state != IDLE);
  assign terms_left = cnt;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Directed-vector bench for mac_accum_ctrl; expected results go into a queue
// that a separate monitor drains on each result handshake.
module tb_mac_accum_ctrl;
  localparam int PROD_W = 33;
  localparam int ACC_W  = 34;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n, start, prod_valid, acc_ready;
  logic [CNT_W-1:0]  num_terms;
  logic [PROD_W-1:0] prod_data;
  logic              prod_ready, acc_valid, acc_ovf, busy;
  logic [ACC_W-1:0]  acc_data;
  logic [CNT_W-1:0]  terms_left;

  int total = 0;
  int bad   = 0;
  logic [ACC_W:0] sb_q[$];   // {ovf, data}
  bit stim_done = 1'b0;

  mac_accum_ctrl #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
    .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .acc_data(acc_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_ovf(acc_ovf), .busy(busy), .terms_left(terms_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [CNT_W-1:0] n);
    start = 1'b1;
    num_terms = n;
    tick();
    start = 1'b0;
    num_terms = 8'hAA;
  endtask

  // Present one product; the monitor-independent checks confirm ACC-state outputs.
  task automatic xfer(input logic [PROD_W-1:0] p, input logic [CNT_W-1:0] exp_left);
    prod_valid = 1'b1;
    prod_data  = p;
    @(negedge clk);
    check("prod_ready_in_acc", {63'd0, prod_ready}, 64'd1);
    check("terms_left", {56'd0, terms_left}, {56'd0, exp_left});
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic gap(input logic [CNT_W-1:0] exp_left);
    prod_valid = 1'b0;
    prod_data  = 33'h1_2345_6789;
    @(negedge clk);
    check("terms_left_hold", {56'd0, terms_left}, {56'd0, exp_left});
    tick();
  endtask

  // Called right after the final transfer edge: result must be up now, then drains.
  task automatic finish_job();
    @(negedge clk);
    check("valid_latency", {63'd0, acc_valid}, 64'd1);
    check("done_prod_ready", {63'd0, prod_ready}, 64'd0);
    tick();
    @(negedge clk);
    check("idle_after_hs", {62'd0, busy, acc_valid}, 64'd0);
    tick();
  endtask

  // Monitor: pops the expected result whenever the DUT completes a handshake.
  always @(negedge clk) begin
    if (acc_valid === 1'b1 && acc_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got data=0x%0h ovf=%0b expected none", acc_data, acc_ovf);
      end else begin
        logic [ACC_W:0] e;
        e = sb_q.pop_front();
        check("result_data", {30'd0, acc_data}, {30'd0, e[ACC_W-1:0]});
        check("result_ovf", {63'd0, acc_ovf}, {63'd0, e[ACC_W]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of test expected finish by 20000ns");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_terms = '0; prod_data = '0;
    prod_valid = 1'b0; acc_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_outputs", {56'd0, prod_ready, acc_valid, acc_ovf, busy, 4'd0},  64'd0);
    check("rst_acc_data", {30'd0, acc_data}, 64'd0);
    check("rst_terms_left", {56'd0, terms_left}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 5 + 7 + 9
    sb_q.push_back({1'b0, 34'd21});
    start_job(8'd3);
    xfer(33'd5, 8'd3); xfer(33'd7, 8'd2); xfer(33'd9, 8'd1);
    finish_job();
    check("data_readable_idle", {30'd0, acc_data}, 64'd21);

    // Two max products: no carry; four: carry out
    sb_q.push_back({1'b0, 34'h3_FFFF_FFFE});
    start_job(8'd2);
    xfer(33'h1_FFFF_FFFF, 8'd2); xfer(33'h1_FFFF_FFFF, 8'd1);
    finish_job();
    sb_q.push_back({1'b1, 34'h3_FFFF_FFFC});
    start_job(8'd4);
    for (int i = 0; i < 4; i++) xfer(33'h1_FFFF_FFFF, 8'(4 - i));
    finish_job();

    // Gapped valid pattern 1,0,0,1,1,0,1
    sb_q.push_back({1'b0, 34'd10});
    start_job(8'd4);
    xfer(33'd1, 8'd4); gap(8'd3); gap(8'd3);
    xfer(33'd2, 8'd3); xfer(33'd3, 8'd2); gap(8'd1);
    xfer(33'd4, 8'd1);
    finish_job();

    // Result stall with start and prod_valid noise
    sb_q.push_back({1'b0, 34'h55});
    acc_ready = 1'b0;
    start_job(8'd1);
    xfer(33'h55, 8'd1);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      num_terms = 8'd7;
      prod_valid = 1'b1;
      prod_data = 33'd1000;
      @(negedge clk);
      check("stall_valid", {63'd0, acc_valid}, 64'd1);
      check("stall_data", {30'd0, acc_data}, 64'h55);
      check("stall_ctrl", {54'd0, prod_ready, busy, terms_left}, {54'd0, 1'b0, 1'b1, 8'd0});
      tick();
    end
    start = 1'b0; prod_valid = 1'b0;
    acc_ready = 1'b1;
    tick();
    @(negedge clk);
    check("stall_release_idle", {62'd0, busy, acc_valid}, 64'd0);
    tick();

    // Zero-term job with a product offered that must be ignored
    sb_q.push_back({1'b0, 34'd0});
    prod_valid = 1'b1; prod_data = 33'd77;
    start_job(8'd0);
    @(negedge clk);
    check("zero_job_done", {61'd0, acc_valid, busy, prod_ready}, {61'd0, 3'b110});
    tick();
    prod_valid = 1'b0;
    @(negedge clk);
    check("zero_job_idle", {62'd0, busy, acc_valid}, 64'd0);
    tick();

    // Abort mid-job with reset, then a fresh job
    start_job(8'd5);
    xfer(33'd10, 8'd5); xfer(33'd20, 8'd4);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("abort_outputs", {59'd0, prod_ready, acc_valid, acc_ovf, busy, 1'b0}, 64'd0);
    check("abort_acc_data", {30'd0, acc_data}, 64'd0);
    check("abort_terms_left", {56'd0, terms_left}, 64'd0);
    rst_n = 1'b1;
    tick();
    sb_q.push_back({1'b0, 34'd3});
    start_job(8'd1);
    xfer(33'd3, 8'd1);
    finish_job();

    tick();
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    stim_done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
